// File: rtl/usb_pkg.sv
// Shared packet definitions for the USB bridge TX scheduler and RX command parser.
package usb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CSUM
    } tx_state_e;

    localparam int          HDR_LEN       = 4;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    localparam logic [1:0]  HDR_OFF_SYNC   = 2'd0;
    localparam logic [1:0]  HDR_OFF_SRC    = 2'd1;
    localparam logic [1:0]  HDR_OFF_LEN_HI = 2'd2;
    localparam logic [1:0]  HDR_OFF_LEN_LO = 2'd3;

    function automatic logic [7:0] hdr_byte(
        input logic [7:0]  sync,
        input logic [7:0]  src,
        input logic [15:0] len,
        input logic [1:0]  off
    );
        logic [7:0] b;
        case (off)
            HDR_OFF_SYNC:   b = sync;
            HDR_OFF_SRC:    b = src;
            HDR_OFF_LEN_HI: b = len[15:8];
            default:        b = len[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = IDX_W'((32'(ptr_i) + 32'(k)) % NUM_SRC);
            if (!any_o && req_i[pos]) begin
                grant_o[pos] = 1'b1;
                idx_o        = pos;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Shares the FT232H TX write port between NUM_SRC producers, framing each
// granted payload with a 4-byte header and an XOR checksum trailer.
module usb_tx_arbiter
    import usb_pkg::*;
#(
    parameter int         NUM_SRC   = 2,
    parameter int         LEN_W     = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_SRC-1:0]             src_req_i,
    input  logic [NUM_SRC-1:0][LEN_W-1:0]  src_len_i,
    input  logic [NUM_SRC-1:0][7:0]        src_data_i,
    input  logic [NUM_SRC-1:0]             src_valid_i,
    output logic [NUM_SRC-1:0]             src_ready_o,
    output logic [NUM_SRC-1:0]             src_grant_o,
    output logic [NUM_SRC-1:0]             src_done_o,
    output logic                           txe_wrreq_o,
    output logic [7:0]                     txe_wrdata_o,
    input  logic                           txe_wrfull_i,
    output logic                           busy_o
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    tx_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [7:0]         csum_q, csum_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [NUM_SRC-1:0] done_q, done_d;

    logic [NUM_SRC-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic               wr_valid;
    logic [7:0]         wr_data;
    logic [NUM_SRC-1:0] ready;
    logic               sel_valid;
    logic [7:0]         sel_data;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i   (src_req_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign sel_valid = src_valid_i[idx_q];
    assign sel_data  = src_data_i[idx_q];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        len_d    = len_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        grant_d  = grant_q;
        done_d   = '0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        ready    = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    idx_d   = arb_idx;
                    len_d   = src_len_i[arb_idx];
                    rem_d   = src_len_i[arb_idx];
                    cnt_d   = '0;
                    csum_d  = 8'h00;
                    grant_d = arb_grant;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                wr_valid = 1'b1;
                wr_data  = hdr_byte(SYNC_BYTE, 8'(idx_q), 16'(len_q), cnt_q);
                if (!txe_wrfull_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(HDR_LEN - 1)) begin
                        state_d = (len_q != '0) ? ST_PAYLOAD : ST_CSUM;
                    end
                end
            end
            ST_PAYLOAD: begin
                wr_valid = sel_valid;
                wr_data  = sel_data;
                if (sel_valid && !txe_wrfull_i) begin
                    ready[idx_q] = 1'b1;
                    csum_d       = csum_q ^ sel_data;
                    rem_d        = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            default: begin
                wr_valid = 1'b1;
                wr_data  = csum_q;
                if (!txe_wrfull_i) begin
                    done_d[idx_q] = 1'b1;
                    grant_d       = '0;
                    rr_ptr_d      = (idx_q == IDX_W'(NUM_SRC - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_d       = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            csum_q   <= 8'h00;
            grant_q  <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
        end
    end

    // The write strobe must drop in the same cycle the FIFO reports full.
    assign txe_wrreq_o  = wr_valid & ~txe_wrfull_i;
    assign txe_wrdata_o = wr_data;
    assign src_ready_o  = ready;
    assign src_grant_o  = grant_q;
    assign src_done_o   = done_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Randomized bench for usb_tx_arbiter against a packet-level reference model.
module tb_usb_tx_arbiter;

    localparam int NS = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    src_req;
    logic [NS-1:0][15:0] src_len;
    logic [NS-1:0][7:0]  src_data;
    logic [NS-1:0]    src_valid;
    logic [NS-1:0]    src_ready;
    logic [NS-1:0]    src_grant;
    logic [NS-1:0]    src_done;
    logic             txe_wrreq;
    logic [7:0]       txe_wrdata;
    logic             txe_full;
    logic             busy;

    usb_tx_arbiter #(.NUM_SRC(NS), .LEN_W(16), .SYNC_BYTE(8'hA5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .src_req_i    (src_req),
        .src_len_i    (src_len),
        .src_data_i   (src_data),
        .src_valid_i  (src_valid),
        .src_ready_o  (src_ready),
        .src_grant_o  (src_grant),
        .src_done_o   (src_done),
        .txe_wrreq_o  (txe_wrreq),
        .txe_wrdata_o (txe_wrdata),
        .txe_wrfull_i (txe_full),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: pending packets per source, current owner, bytes written.
    int          pq_len[NS][$];
    logic [7:0]  pq_data[NS][$];
    int          bptr[NS];
    int          owner = -1;
    int          pos = 0;
    int          cur_len = 0;
    int          ptr = 0;
    logic [7:0]  exp_q[$];
    logic [NS-1:0] exp_done = '0;
    int          done_cnt[NS];
    int          wr_cnt = 0;
    int          order[$];

    int valid_pct = 100;
    int full_pct = 0;
    int full_force = 0;
    bit valid_toggle = 0;
    bit tog = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        pq_len[s].push_back(len);
        for (int i = 0; i < len; i++) pq_data[s].push_back(8'($urandom));
    endtask

    task automatic drive();
        tog = ~tog;
        for (int s = 0; s < NS; s++) begin
            src_req[s] = (pq_len[s].size() > 0);
            if (owner == s || pq_len[s].size() == 0)
                src_len[s] = 16'($urandom);
            else
                src_len[s] = 16'(pq_len[s][0]);
            if (pq_len[s].size() > 0 && bptr[s] < pq_len[s][0])
                src_data[s] = pq_data[s][bptr[s]];
            else
                src_data[s] = 8'($urandom);
            src_valid[s] = valid_toggle ? tog : ($urandom_range(99) < valid_pct);
        end
        if (full_force > 0) begin
            txe_full = 1'b1;
            full_force--;
        end else begin
            txe_full = ($urandom_range(99) < full_pct);
        end
    endtask

    task automatic sample();
        bit was_idle;
        bit in_pay;
        bit exp_wr;
        logic [NS-1:0] eg;
        logic [NS-1:0] er;
        logic [7:0] eb;
        logic [7:0] cs;
        was_idle = (owner < 0);
        check_eq("done", src_done, exp_done);
        for (int s = 0; s < NS; s++) if (src_done[s]) done_cnt[s]++;
        exp_done = '0;
        if (owner < 0) begin
            eg = '0; er = '0; exp_wr = 0; in_pay = 0;
        end else begin
            eg = NS'(1) << owner;
            in_pay = (pos >= 4) && (pos < 4 + cur_len);
            exp_wr = !txe_full && (!in_pay || src_valid[owner]);
            er = (in_pay && src_valid[owner] && !txe_full) ? eg : '0;
        end
        check_eq("grant", src_grant, eg);
        check_eq("ready", src_ready, er);
        check_eq("wrreq", txe_wrreq, exp_wr);
        check_eq("busy", busy, owner >= 0);
        if (exp_wr) begin
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            check_eq("wrdata", txe_wrdata, eb);
            wr_cnt++;
            pos++;
            if (in_pay) bptr[owner]++;
            if (pos == cur_len + 5) begin
                exp_done = NS'(1) << owner;
                void'(pq_len[owner].pop_front());
                for (int i = 0; i < cur_len; i++) void'(pq_data[owner].pop_front());
                bptr[owner] = 0;
                ptr = (owner + 1) % NS;
                owner = -1;
            end
        end
        if (was_idle) begin
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (ptr + k) % NS;
                if (owner < 0 && pq_len[s].size() > 0) begin
                    owner = s;
                    pos = 0;
                    cur_len = pq_len[s][0];
                    order.push_back(s);
                    exp_q.delete();
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(8'(s));
                    exp_q.push_back(8'(cur_len >> 8));
                    exp_q.push_back(8'(cur_len));
                    cs = 8'h00;
                    for (int i = 0; i < cur_len; i++) begin
                        exp_q.push_back(pq_data[s][i]);
                        cs ^= pq_data[s][i];
                    end
                    exp_q.push_back(cs);
                end
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pending();
        bit p;
        p = (owner >= 0);
        for (int s = 0; s < NS; s++) if (pq_len[s].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        check_eq(tag, n < budget, 1'b1);
    endtask

    initial begin
        int w0;
        int n;
        int d0;
        rst = 1'b1;
        src_req = '0; src_len = '0; src_data = '0; src_valid = '0; txe_full = 1'b0;
        for (int s = 0; s < NS; s++) begin bptr[s] = 0; done_cnt[s] = 0; end
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_grant", src_grant, '0);
        check_eq("rst_done", src_done, '0);
        check_eq("rst_ready", src_ready, '0);
        check_eq("rst_wrreq", txe_wrreq, 1'b0);
        check_eq("rst_wrdata", txe_wrdata, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed: source 0, len 3, bytes 11 22 33.
        pq_len[0].push_back(3);
        pq_data[0].push_back(8'h11); pq_data[0].push_back(8'h22); pq_data[0].push_back(8'h33);
        w0 = wr_cnt;
        drain("drain_basic", 100);
        check_eq("basic_writes", wr_cnt - w0, 8);
        check_eq("basic_done0", done_cnt[0], 1);

        // Two sources contending with len 1 packets alternate.
        order.delete();
        for (int i = 0; i < 3; i++) begin add_pkt(0, 1); add_pkt(1, 1); end
        drain("drain_alt", 200);
        check_eq("alt_count", order.size(), 6);
        for (int i = 1; i < order.size(); i++)
            check_eq("alt_order", order[i], (order[i-1] + 1) % 2);

        // Zero-length packet on source 1.
        w0 = wr_cnt;
        d0 = done_cnt[1];
        add_pkt(1, 0);
        drain("drain_len0", 100);
        check_eq("len0_writes", wr_cnt - w0, 5);
        check_eq("len0_done1", done_cnt[1] - d0, 1);

        // FIFO full for 5 cycles while payload byte 2 of 4 is pending.
        add_pkt(0, 4);
        n = 0;
        while (!(owner == 0 && pos == 5) && n < 50) begin cycle(); n++; end
        check_eq("reach_byte2", owner == 0 && pos == 5, 1'b1);
        full_force = 5;
        drain("drain_full", 100);

        // Valid toggling on a 256-byte packet.
        valid_toggle = 1;
        w0 = wr_cnt;
        add_pkt(2, 256);
        drain("drain_256", 2000);
        check_eq("len256_writes", wr_cnt - w0, 261);
        valid_toggle = 0;

        // Random traffic with random backpressure and payload gaps.
        valid_pct = 70;
        full_pct = 20;
        for (int i = 0; i < 40; i++) add_pkt($urandom_range(NS - 1), $urandom_range(12));
        drain("drain_rand", 8000);

        // Reset mid-payload, then source 1 alone must win from rr_ptr 0.
        valid_pct = 100;
        full_pct = 0;
        add_pkt(0, 20);
        n = 0;
        while (!(owner == 0 && pos >= 8) && n < 100) begin cycle(); n++; end
        check_eq("reach_mid", owner == 0 && pos >= 8, 1'b1);
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1 rst = 1'b0;
        if (owner >= 0) begin
            void'(pq_len[owner].pop_front());
            for (int i = 0; i < cur_len; i++) void'(pq_data[owner].pop_front());
        end
        for (int s = 0; s < NS; s++) bptr[s] = 0;
        owner = -1; ptr = 0; exp_q.delete(); exp_done = '0;
        add_pkt(1, 2);
        order.delete();
        drive();
        @(negedge clk);
        check_eq("post_rst_wrdata", txe_wrdata, 8'h00);
        sample();
        @(posedge clk);
        #1;
        drain("drain_rst", 100);
        check_eq("post_rst_grant", (order.size() > 0) ? order[0] : -1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_arbiter.md
# usb_tx_arbiter

Packet scheduler that shares the TX write port of the FT232H USB bridge between up to NUM_SRC producers (image line stream, status/response channel, debug). It grants one source at a time in round-robin order, frames its payload with a fixed header and XOR checksum trailer, and writes bytes into the TX FIFO only while that FIFO is not full. It sits in the scanner's system clock domain, directly in front of the bridge's TX write port.

## Interface
- NUM_SRC, 2, number of requesting sources (2..8)
- LEN_W, 16, payload length width in bytes
- SYNC_BYTE, 8'hA5, first header byte of every packet
- clk_i  in  1  system clock; also drives the TX FIFO write clock
- rst_i  in  1  synchronous, active-high reset
- src_req_i  in  NUM_SRC  packet request per source; level, held until src_done_o
- src_len_i  in  NUM_SRC x LEN_W  payload byte count; sampled at grant
- src_data_i  in  NUM_SRC x 8  payload byte
- src_valid_i  in  NUM_SRC  payload byte valid
- src_ready_o  out  NUM_SRC  payload byte accepted this cycle
- src_grant_o  out  NUM_SRC  one-hot; source owns the port
- src_done_o  out  NUM_SRC  one-cycle pulse after that source's checksum byte is written
- txe_wrreq_o  out  1  TX FIFO write request
- txe_wrdata_o  out  8  TX FIFO write data
- txe_wrfull_i  in  1  TX FIFO full
- busy_o  out  1  high whenever state is not IDLE

## Operation
- Packet on the wire: SYNC_BYTE, source index (8 bits, zero-extended), len[15:8], len[7:0], len payload bytes, checksum = XOR of all payload bytes (8'h00 when len = 0).
- States: IDLE, HDR, PAYLOAD, CSUM.
- IDLE: if any src_req_i is high, the round-robin arbiter picks the first requester at or after rr_ptr (wrapping); latch index and length, set src_grant_o, clear checksum and byte counter, go to HDR. No request: stay.
- HDR: emit the 4 header bytes in order, one per write; counter 0..3. After byte 3: go to PAYLOAD if len != 0, else CSUM.
- PAYLOAD: byte transfers when granted src_valid_i = 1 and txe_wrfull_i = 0; then src_ready_o = 1, txe_wrreq_o = 1, txe_wrdata_o = src_data_i, checksum ^= byte, remaining count decrements. Last byte transferred -> CSUM.
- CSUM: emit checksum byte; on write, pulse src_done_o for the granted source, clear grant, set rr_ptr = granted index + 1 (mod NUM_SRC), go to IDLE.
- A write happens in a cycle only when txe_wrfull_i = 0; txe_wrreq_o is therefore combinational (state-valid AND NOT txe_wrfull_i); all state is registered.
- src_req_i deasserted mid-packet is ignored; the latched length is completed. src_len_i changes after grant are ignored.
- Length arithmetic: remaining count is LEN_W bits, no wrap; len = 2^LEN_W - 1 is legal.
- Reset mid-packet: all state to IDLE, rr_ptr = 0, packet truncated in the FIFO; the host resynchronises on SYNC_BYTE.

## Timing
- Reset values: src_ready_o = 0, src_grant_o = 0, src_done_o = 0, txe_wrreq_o = 0, txe_wrdata_o = 8'h00, busy_o = 0.
- Request seen in IDLE at edge N -> src_grant_o high and first header write possible from cycle N+1.
- Unstalled packet of L bytes: 4 + L + 1 write cycles plus 1 IDLE arbitration cycle; the next grant is decided in the cycle after src_done_o.
- txe_wrfull_i high: no write, no state or counter change, src_ready_o = 0; resumes in the first cycle it is low.
- src_valid_i low in PAYLOAD: stall with no write.
- Simultaneous requests: resolved by rr_ptr only; a continuously requesting source is served at most once per NUM_SRC grants while others wait.

## Structure
- Package usb_pkg: state enum (IDLE, HDR, PAYLOAD, CSUM), HDR_LEN = 4, SYNC_BYTE default, packet-field constants shared with the RX command parser.
- Sub-module rr_arbiter (NUM_SRC): request vector plus pointer in, one-hot grant and index out, purely combinational.

## Test plan
- Single source 0, len 3, bytes 11 22 33, FIFO never full -> writes A5 00 00 03 11 22 33 00; src_done_o[0] pulses once; 8 consecutive writes.
- Both sources requesting continuously, len 1 each -> grants alternate 0,1,0,1; header byte 2 shows 00/01 alternating.
- len 0 on source 1 -> exactly A5 01 00 00 00; src_ready_o never asserted.
- txe_wrfull_i high for 5 cycles during payload byte 2 of len 4 -> no writes and byte order preserved; checksum correct.
- src_valid_i toggled every other cycle, len 256 -> 261 writes, length bytes 01 00, checksum matches XOR.
- rst_i asserted mid-payload -> next cycle all outputs at reset values; next request from source 1 with rr_ptr 0 still grants 1 if source 0 idle.
